// File: rtl/uart_ram_loader_pkg.sv
// Shared types and widths for the UART-to-RAM loader.
// Optional 8E1 framing is selected with UART_RAM_LOADER_PARITY_EN.
package uart_ram_loader_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: rx synchroniser, bit-timing counter and frame FSM.
// Define UART_RAM_LOADER_PARITY_EN for 8E1 frames; default is 8N1.
module uart_rx_byte
    import uart_ram_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              byte_valid_c,
    output logic [BYTE_W-1:0] byte_c,
    output logic              err_c,
    output logic              busy
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);

    logic              rx_meta_q;
    logic              rxs_q;
    rx_state_e         state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shift_q,   shift_d;
    logic              armed_q,   armed_d;
    logic              busy_q,    busy_d;
`ifdef UART_RAM_LOADER_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_RAM_LOADER_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
            busy_q    <= busy_d;
`ifdef UART_RAM_LOADER_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // A line left low after a bad stop bit must go high before a new start counts.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        armed_d      = armed_q | rxs_q;
        byte_valid_c = 1'b0;
        err_c        = 1'b0;
`ifdef UART_RAM_LOADER_PARITY_EN
        par_err_d    = par_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rxs_q && armed_q) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        cnt_d     = CNT_FULL;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs_q, shift_q[BYTE_W-1:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RAM_LOADER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UART_RAM_LOADER_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    par_err_d = rxs_q ^ (^shift_q);
                    state_d   = STOP;
                    cnt_d     = CNT_FULL;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
`ifdef UART_RAM_LOADER_PARITY_EN
                    if (rxs_q && !par_err_q) begin
`else
                    if (rxs_q) begin
`endif
                        byte_valid_c = 1'b1;
                    end else begin
                        err_c   = 1'b1;
                        armed_d = rxs_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign byte_c = shift_q;
    assign busy   = busy_q;

endmodule

// File: rtl/uart_ram_loader.sv
// Pairs received UART bytes little-endian into 16-bit RAM writes at incrementing addresses.
// UART_RAM_LOADER_PARITY_EN selects 8E1 framing in the byte receiver.
module uart_ram_loader
    import uart_ram_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_err
);

    logic              byte_valid_c;
    logic [BYTE_W-1:0] byte_c;
    logic              err_c;

    uart_rx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .byte_valid_c (byte_valid_c),
        .byte_c       (byte_c),
        .err_c        (err_c),
        .busy         (busy)
    );

    logic              half_q,      half_d;
    logic [BYTE_W-1:0] low_q,       low_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,   wr_data_d;
    logic              frame_err_q, frame_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            half_q      <= 1'b0;
            low_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            half_q      <= half_d;
            low_q       <= low_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Address advances the cycle after each write strobe and wraps naturally.
    always_comb begin
        half_d      = half_q;
        low_d       = low_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        frame_err_d = err_c;
        wr_addr_d   = wr_en_q ? wr_addr_q + ADDR_W'(1) : wr_addr_q;
        if (err_c) begin
            half_d = 1'b0;
        end else if (byte_valid_c) begin
            if (!half_q) begin
                low_d  = byte_c;
                half_d = 1'b1;
            end else begin
                wr_en_d   = 1'b1;
                wr_data_d = {byte_c, low_q};
                half_d    = 1'b0;
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Scoreboard bench for uart_ram_loader with CLK_DIV = 4.
module tb_uart_ram_loader;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned ADDR_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              busy;
    logic              frame_err;

    uart_ram_loader #(
        .CLK_DIV (CLK_DIV),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  err_exp  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe and error pulse must match an expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr_en", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                check("wr_data", 32'(wr_data), 32'(mon_e.data));
            end
        end
        if (rst === 1'b0 && frame_err === 1'b1) begin
            check("frame_err_expected", 32'(err_exp > 0), 32'd1);
            if (err_exp > 0) err_exp--;
        end
    end

    task automatic bit_out(input logic v);
        rx = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RAM_LOADER_PARITY_EN
        bit_out(^b);
`endif
        bit_out(stop_v);
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [15:0] w);
        exp_q.push_back({addr, w});
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || err_exp != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_writes", 32'(exp_q.size()), 32'd0);
        check("drain_errors", 32'(err_exp), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        err_exp = 0;
        rst = 1'b0;
    endtask

    logic [15:0] fill [10];

    initial begin
        fill = '{16'h0001, 16'hAAAA, 16'h5555, 16'hFFFF, 16'hF0F0,
                 16'h0F0F, 16'hCCCC, 16'h3333, 16'h0002, 16'h0004};
        rst = 1'b1;
        rx  = 1'b1;
        do_reset();
        check("rst_wr_en",     32'(wr_en),     32'd0);
        check("rst_wr_addr",   32'(wr_addr),   32'd0);
        check("rst_wr_data",   32'(wr_data),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);

        // Basic write
        send_word(10'd0, 16'h0001);
        drain();

        // Sequential fill from a fresh reset
        do_reset();
        for (int i = 0; i < 10; i++) send_word(ADDR_W'(i), fill[i]);
        drain();
        check("fill_final_addr", 32'(wr_addr), 32'd10);

        // Bad stop bit, then a line-high gap before the next frame
        err_exp++;
        send_byte(8'h34, 1'b0);
        bit_out(1'b1);
        send_word(10'd10, 16'h5678);
        drain();

        // One-cycle glitch while idle
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_addr", 32'(wr_addr), 32'd11);

        // Fill to the top of the address space and wrap
        for (int a = 11; a < 1023; a++) send_word(ADDR_W'(a), 16'(a * 7 + 3));
        send_word(10'd1023, 16'hBEEF);
        send_word(10'd0,    16'hCAFE);
        drain();
        check("wrap_addr_after", 32'(wr_addr), 32'd1);

        // Reset during the data bits of the second byte
        send_byte(8'h11, 1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        rx  = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_addr", 32'(wr_addr), 32'd0);
        check("midrst_busy", 32'(busy),    32'd0);
        send_word(10'd0, 16'hABCD);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
